// File: rtl/int_pkg.sv
// Shared constants, gateway state encoding and field helper for the interrupt claim arbiter.
package int_pkg;

  localparam int NSRC   = 31;
  localparam int PRIO_W = 3;
  localparam int ID_W   = 5;

  typedef enum logic [1:0] {
    GW_IDLE = 2'd0,
    GW_PEND = 2'd1,
    GW_INFL = 2'd2
  } gw_state_e;

  // Extract the priority field of source idx from the packed priority vector.
  function automatic logic [PRIO_W-1:0] prio_of(input logic [(NSRC+1)*PRIO_W-1:0] vec,
                                                input int idx);
    prio_of = vec[idx*PRIO_W +: PRIO_W];
  endfunction

endpackage

// File: rtl/int_gateway.sv
// Per-source gateway: IDLE/PEND/INFL state machine with level or (INT_EDGE_TRIG_EN) edge trigger.
module int_gateway
  import int_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic irq,
  input  logic claim,
  input  logic cmpl,
  output logic pend
);

  gw_state_e state_q, state_d;
  logic      trig_s;

`ifdef INT_EDGE_TRIG_EN
  logic irq_prev_q, irq_prev_d;

  assign irq_prev_d = irq;

  // Previous-sample flop used to detect rising edges of the source line.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_prev_q <= 1'b0;
    end else begin
      irq_prev_q <= irq_prev_d;
    end
  end

  assign trig_s = irq & ~irq_prev_q;
`else
  assign trig_s = irq;
`endif

  // Gateway state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= GW_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; triggers arriving while PEND or INFL are dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      GW_IDLE: begin
        if (trig_s) begin
          state_d = GW_PEND;
        end else begin
          state_d = GW_IDLE;
        end
      end
      GW_PEND: begin
        if (claim) begin
          state_d = GW_INFL;
        end else begin
          state_d = GW_PEND;
        end
      end
      GW_INFL: begin
        if (cmpl) begin
          state_d = GW_IDLE;
        end else begin
          state_d = GW_INFL;
        end
      end
      default: state_d = GW_IDLE;
    endcase
  end

  assign pend = (state_q == GW_PEND);

endmodule

// File: rtl/int_claim_arb.sv
// Interrupt gateways, registered priority arbiter and claim/complete engine for one hart.
// Optional build macro: INT_EDGE_TRIG_EN selects edge-triggered gateways (default: level).
module int_claim_arb
  import int_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NSRC:0]              src_irq,
  input  logic [NSRC:0]              src_ie,
  input  logic [(NSRC+1)*PRIO_W-1:0] src_prio,
  input  logic [PRIO_W-1:0]          threshold,
  input  logic                       claim_req,
  output logic                       claim_vld,
  output logic [ID_W-1:0]            claim_id,
  input  logic                       cmpl_req,
  input  logic [ID_W-1:0]            cmpl_id,
  output logic [NSRC:0]              pending,
  output logic                       eip
);

  logic [NSRC:0]     pend_s;
  logic [NSRC:0]     cand_s;
  logic [NSRC:0]     gw_claim_s;
  logic [NSRC:0]     gw_cmpl_s;
  logic              claim_ok_s;

  logic [ID_W-1:0]   best_id_q, best_id_d;
  logic [PRIO_W-1:0] best_prio_q, best_prio_d;
  logic              eip_q, eip_d;
  logic              claim_vld_q, claim_vld_d;
  logic [ID_W-1:0]   claim_id_q, claim_id_d;

  assign pend_s[0]     = 1'b0;
  assign cand_s[0]     = 1'b0;
  assign gw_claim_s[0] = 1'b0;
  assign gw_cmpl_s[0]  = 1'b0;

  // A claim is honoured only if last cycle's winner is still a candidate now.
  assign claim_ok_s = claim_req & (best_id_q != {ID_W{1'b0}}) & cand_s[best_id_q];

  for (genvar g = 1; g <= NSRC; g++) begin : gen_src
    assign cand_s[g]     = pend_s[g] & src_ie[g] & (prio_of(src_prio, g) > threshold);
    assign gw_claim_s[g] = claim_ok_s & (best_id_q == ID_W'(g));
    assign gw_cmpl_s[g]  = cmpl_req & (cmpl_id == ID_W'(g));

    int_gateway u_gw (
      .clk   (clk),
      .rst   (rst),
      .irq   (src_irq[g]),
      .claim (gw_claim_s[g]),
      .cmpl  (gw_cmpl_s[g]),
      .pend  (pend_s[g])
    );
  end

  // Priority search: strict greater-than keeps the lowest ID on ties.
  always_comb begin
    best_id_d   = {ID_W{1'b0}};
    best_prio_d = {PRIO_W{1'b0}};
    for (int i = 1; i <= NSRC; i++) begin
      if (cand_s[i] && (prio_of(src_prio, i) > best_prio_d)) begin
        best_id_d   = ID_W'(i);
        best_prio_d = prio_of(src_prio, i);
      end else begin
        best_id_d   = best_id_d;
        best_prio_d = best_prio_d;
      end
    end
  end

  // Next values for the hart request and the claim response.
  always_comb begin
    eip_d       = (best_id_d != {ID_W{1'b0}});
    claim_vld_d = claim_req;
    if (claim_ok_s) begin
      claim_id_d = best_id_q;
    end else begin
      claim_id_d = {ID_W{1'b0}};
    end
  end

  // Arbiter result and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      best_id_q   <= {ID_W{1'b0}};
      best_prio_q <= {PRIO_W{1'b0}};
      eip_q       <= 1'b0;
      claim_vld_q <= 1'b0;
      claim_id_q  <= {ID_W{1'b0}};
    end else begin
      best_id_q   <= best_id_d;
      best_prio_q <= best_prio_d;
      eip_q       <= eip_d;
      claim_vld_q <= claim_vld_d;
      claim_id_q  <= claim_id_d;
    end
  end

  assign pending   = pend_s;
  assign eip       = eip_q;
  assign claim_vld = claim_vld_q;
  assign claim_id  = claim_id_q;

  // Source 0 inputs and the stored winning priority have no consumer.
  logic unused_s;
  assign unused_s = ^{src_irq[0], src_ie[0], src_prio[PRIO_W-1:0], best_prio_q};

endmodule

// File: tb/tb_int_claim_arb.sv
// Directed self-checking bench for int_claim_arb (level or INT_EDGE_TRIG_EN build).
module tb_int_claim_arb;
  import int_pkg::*;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [NSRC:0]              src_irq;
  logic [NSRC:0]              src_ie;
  logic [(NSRC+1)*PRIO_W-1:0] src_prio;
  logic [PRIO_W-1:0]          threshold;
  logic                       claim_req;
  logic                       claim_vld;
  logic [ID_W-1:0]            claim_id;
  logic                       cmpl_req;
  logic [ID_W-1:0]            cmpl_id;
  logic [NSRC:0]              pending;
  logic                       eip;

  int errors = 0;
  int checks = 0;

  int_claim_arb dut (
    .clk(clk), .rst(rst), .src_irq(src_irq), .src_ie(src_ie), .src_prio(src_prio),
    .threshold(threshold), .claim_req(claim_req), .claim_vld(claim_vld), .claim_id(claim_id),
    .cmpl_req(cmpl_req), .cmpl_id(cmpl_id), .pending(pending), .eip(eip)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; src_irq = '0; src_ie = '0; src_prio = '0; threshold = 3'd0;
    claim_req = 1'b0; cmpl_req = 1'b0; cmpl_id = 5'd0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic cfg(input int id, input logic [PRIO_W-1:0] p);
    src_prio[id*PRIO_W +: PRIO_W] = p;
    src_ie[id] = 1'b1;
  endtask

  task automatic pulse(input logic [NSRC:0] mask);
    src_irq = src_irq | mask;
    tick();
    src_irq = src_irq & ~mask;
    tick();
  endtask

  task automatic do_claim();
    claim_req = 1'b1;
    tick();
    claim_req = 1'b0;
  endtask

  task automatic do_cmpl(input logic [ID_W-1:0] id);
    cmpl_req = 1'b1; cmpl_id = id;
    tick();
    cmpl_req = 1'b0; cmpl_id = 5'd0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pending !== 32'h0) begin errors++; $display("FAIL rst_pending: got %h want %h", pending, 32'h0); end
    checks++; if (eip !== 1'b0) begin errors++; $display("FAIL rst_eip: got %b want 0", eip); end
    checks++; if (claim_vld !== 1'b0) begin errors++; $display("FAIL rst_claim_vld: got %b want 0", claim_vld); end
    checks++; if (claim_id !== 5'd0) begin errors++; $display("FAIL rst_claim_id: got %0d want 0", claim_id); end
    // Source 0 is reserved: its inputs must never produce anything.
    src_irq[0] = 1'b1; cfg(0, 3'd7);
    tick(); tick(); tick();
    checks++; if (pending !== 32'h0) begin errors++; $display("FAIL src0_pending: got %h want %h", pending, 32'h0); end
    checks++; if (eip !== 1'b0) begin errors++; $display("FAIL src0_eip: got %b want 0", eip); end
    do_claim();
    checks++; if (claim_vld !== 1'b1 || claim_id !== 5'd0) begin errors++; $display("FAIL src0_claim: got vld=%b id=%0d want vld=1 id=0", claim_vld, claim_id); end
  endtask

  task automatic test_basic();
    do_reset();
    cfg(3, 3'd2); src_irq[3] = 1'b1;
    tick();
    checks++; if (pending !== 32'h8) begin errors++; $display("FAIL t1_pending: got %h want %h", pending, 32'h8); end
    checks++; if (eip !== 1'b0) begin errors++; $display("FAIL t1_eip_early: got %b want 0", eip); end
    tick();
    checks++; if (eip !== 1'b1) begin errors++; $display("FAIL t1_eip: got %b want 1", eip); end
    src_irq[3] = 1'b0;
    do_claim();
    checks++; if (claim_vld !== 1'b1 || claim_id !== 5'd3) begin errors++; $display("FAIL t1_claim: got vld=%b id=%0d want vld=1 id=3", claim_vld, claim_id); end
    checks++; if (pending !== 32'h0) begin errors++; $display("FAIL t1_pending_claimed: got %h want %h", pending, 32'h0); end
    tick();
    checks++; if (eip !== 1'b0) begin errors++; $display("FAIL t1_eip_drop: got %b want 0", eip); end
    checks++; if (claim_vld !== 1'b0) begin errors++; $display("FAIL t1_vld_pulse: got %b want 0", claim_vld); end
  endtask

  task automatic test_priority();
    do_reset();
    cfg(5, 3'd4); cfg(9, 3'd4); cfg(2, 3'd1);
    pulse(32'h0000_0224);
    checks++; if (pending !== 32'h0000_0224) begin errors++; $display("FAIL t2_pending: got %h want %h", pending, 32'h0000_0224); end
    do_claim();
    checks++; if (claim_id !== 5'd5) begin errors++; $display("FAIL t2_claim1: got %0d want 5", claim_id); end
    tick(); do_claim();
    checks++; if (claim_id !== 5'd9) begin errors++; $display("FAIL t2_claim2: got %0d want 9", claim_id); end
    tick(); do_claim();
    checks++; if (claim_id !== 5'd2) begin errors++; $display("FAIL t2_claim3: got %0d want 2", claim_id); end
    tick(); do_claim();
    checks++; if (claim_vld !== 1'b1 || claim_id !== 5'd0) begin errors++; $display("FAIL t2_claim4: got vld=%b id=%0d want vld=1 id=0", claim_vld, claim_id); end
    checks++; if (eip !== 1'b0) begin errors++; $display("FAIL t2_eip: got %b want 0", eip); end
  endtask

  task automatic test_threshold();
    do_reset();
    cfg(7, 3'd2); threshold = 3'd2;
    pulse(32'h80);
    tick();
    checks++; if (eip !== 1'b0) begin errors++; $display("FAIL t3_eip_masked: got %b want 0", eip); end
    do_claim();
    checks++; if (claim_vld !== 1'b1 || claim_id !== 5'd0) begin errors++; $display("FAIL t3_claim_masked: got vld=%b id=%0d want vld=1 id=0", claim_vld, claim_id); end
    checks++; if (pending !== 32'h80) begin errors++; $display("FAIL t3_pending: got %h want %h", pending, 32'h80); end
    threshold = 3'd1;
    tick();
    checks++; if (eip !== 1'b1) begin errors++; $display("FAIL t3_eip_unmasked: got %b want 1", eip); end
    do_claim();
    checks++; if (claim_id !== 5'd7) begin errors++; $display("FAIL t3_claim: got %0d want 7", claim_id); end
  endtask

  task automatic test_complete();
    do_reset();
    cfg(4, 3'd3);
    pulse(32'h10);
    do_claim();
    checks++; if (claim_id !== 5'd4) begin errors++; $display("FAIL t4_claim: got %0d want 4", claim_id); end
    pulse(32'h10);
    checks++; if (pending !== 32'h0) begin errors++; $display("FAIL t4_repulse_infl: got %h want %h", pending, 32'h0); end
    do_cmpl(5'd6);
    pulse(32'h10);
    checks++; if (pending !== 32'h0) begin errors++; $display("FAIL t4_cmpl_wrong_id: got %h want %h", pending, 32'h0); end
    do_cmpl(5'd4);
    pulse(32'h10);
    checks++; if (pending !== 32'h10) begin errors++; $display("FAIL t4_cmpl_ok: got %h want %h", pending, 32'h10); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cfg(4, 3'd3);
    pulse(32'h10);
    claim_req = 1'b1; cmpl_req = 1'b1; cmpl_id = 5'd4;
    tick();
    claim_req = 1'b0; cmpl_req = 1'b0; cmpl_id = 5'd0;
    checks++; if (claim_id !== 5'd4) begin errors++; $display("FAIL t5_claim: got %0d want 4", claim_id); end
    tick();
    pulse(32'h10);
    checks++; if (pending !== 32'h0 || eip !== 1'b0) begin errors++; $display("FAIL t5_still_infl: got pending=%h eip=%b want pending=0 eip=0", pending, eip); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (pending !== 32'h0 || eip !== 1'b0 || claim_vld !== 1'b0) begin errors++; $display("FAIL t5_rst: got pending=%h eip=%b vld=%b want all 0", pending, eip, claim_vld); end
    pulse(32'h10);
    checks++; if (pending !== 32'h10) begin errors++; $display("FAIL t5_idle_after_rst: got %h want %h", pending, 32'h10); end
    checks++; if (eip !== 1'b1) begin errors++; $display("FAIL t5_eip_after_rst: got %b want 1", eip); end
  endtask

  task automatic test_trigger_mode();
    logic exp_p;
`ifdef INT_EDGE_TRIG_EN
    exp_p = 1'b0;
`else
    exp_p = 1'b1;
`endif
    do_reset();
    cfg(3, 3'd2); src_irq[3] = 1'b1;
    tick(); tick();
    do_claim();
    checks++; if (claim_id !== 5'd3) begin errors++; $display("FAIL t6_claim: got %0d want 3", claim_id); end
    do_cmpl(5'd3);
    tick();
    checks++; if (pending[3] !== exp_p) begin errors++; $display("FAIL t6_repend: got %b want %b", pending[3], exp_p); end
    tick();
    checks++; if (eip !== exp_p) begin errors++; $display("FAIL t6_eip: got %b want %b", eip, exp_p); end
    src_irq[3] = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_threshold();
    test_complete();
    test_back_to_back();
    test_trigger_mode();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
